io_uart_responder: RTL



---
 rtl/io_uart_responder_pkg.sv | 29 ++
 rtl/io_uart_responder_sync_fifo.sv | 47 ++++
 rtl/io_uart_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_uart_responder_pkg.sv
// Shared register map, status bit positions and FSM state type for the
// memory-mapped UART responder.
package io_uart_responder_pkg;

  localparam logic [15:0] IO_UART_STATUS = 16'h0000;
  localparam logic [15:0] IO_UART_RX     = 16'h0004;
  localparam logic [15:0] IO_UART_TX     = 16'h0008;
  localparam logic [15:0] IO_UART_DIV    = 16'h000C;

  localparam int STATUS_RX_AVAIL    = 0;
  localparam int STATUS_TX_READY    = 1;
  localparam int STATUS_RX_OVERRUN  = 2;
  localparam int STATUS_FRAMING_ERR = 3;

  localparam logic [2:0] UART_LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // A bit period shorter than two clocks leaves no room for a mid-bit sample.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/io_uart_responder_sync_fifo.sv
// Synchronous FIFO with show-ahead head; a push while full is dropped unless
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/io_uart_responder.sv
// IO-bus UART responder: STATUS/RX/TX/DIVISOR registers, buffered 8N1
// transmitter and receiver, combinational read data.
module io_uart_responder
  import io_uart_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDRESS  = 16'h0000,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] DIVISOR_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic [15:0] offset;
  logic        wr_status, wr_tx, wr_div, rd_rx;
  logic [15:0] divisor;
  logic        rx_overrun, framing_err;
  logic [3:0]  status_bits;
  logic        unused_bits;

  logic [7:0]  tx_head, rx_head;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_pop, rx_pop;

  uart_state_t tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d, tx_len, tx_len_d;
  logic [2:0]  tx_idx, tx_idx_d;
  logic [7:0]  tx_shift, tx_shift_d;

  logic        rx_meta, rx_sync;
  uart_state_t rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d, rx_len, rx_len_d;
  logic [2:0]  rx_idx, rx_idx_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_armed, rx_armed_d;
  logic        rx_stop_ok, rx_stop_bad, rx_overrun_set;

  assign unused_bits = &{1'b0, io_address[31:16], io_write_data[31:16]};

  assign offset    = io_address[15:0] - BASE_ADDRESS;
  assign wr_status = io_write_en && (offset == IO_UART_STATUS);
  assign wr_tx     = io_write_en && (offset == IO_UART_TX);
  assign wr_div    = io_write_en && (offset == IO_UART_DIV);
  assign rd_rx     = io_read_en  && (offset == IO_UART_RX);
  assign rx_pop    = rd_rx && !rx_empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    status_bits                     = '0;
    status_bits[STATUS_RX_AVAIL]    = !rx_empty;
    status_bits[STATUS_TX_READY]    = !tx_full;
    status_bits[STATUS_RX_OVERRUN]  = rx_overrun;
    status_bits[STATUS_FRAMING_ERR] = framing_err;
  end

  always_comb begin
    io_read_data = '0;
    if (io_read_en) begin
      case (offset)
        IO_UART_STATUS: io_read_data = {28'd0, status_bits};
        IO_UART_RX:     io_read_data = rx_empty ? 32'd0 : {24'd0, rx_head};
        IO_UART_DIV:    io_read_data = {16'd0, divisor};
        default:        io_read_data = '0;
      endcase
    end
  end

  // A set in the same cycle as a write-1-clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor     <= DIVISOR_RESET;
      rx_overrun  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (wr_div) divisor <= clamp_divisor(io_write_data[15:0]);
      rx_overrun  <= rx_overrun_set ||
                     (rx_overrun && !(wr_status && io_write_data[STATUS_RX_OVERRUN]));
      framing_err <= rx_stop_bad ||
                     (framing_err && !(wr_status && io_write_data[STATUS_FRAMING_ERR]));
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(tx_pop),
    .data_in(io_write_data[7:0]), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_stop_ok), .pop(rx_pop),
    .data_in(rx_shift), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // Transmitter: the bit length is relatched from divisor at every bit boundary.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_len_d   = tx_len;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      UART_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = UART_START;
          tx_cnt_d   = '0;
          tx_len_d   = divisor;
        end
      end
      default: begin
        if (tx_cnt == tx_len - 16'd1) begin
          tx_cnt_d = '0;
          tx_len_d = divisor;
          case (tx_state)
            UART_START: begin
              tx_state_d = UART_DATA;
              tx_idx_d   = '0;
            end
            UART_DATA: begin
              tx_shift_d = {1'b0, tx_shift[7:1]};
              if (tx_idx == UART_LAST_BIT) tx_state_d = UART_STOP;
              else                         tx_idx_d   = tx_idx + 3'd1;
            end
            default: begin
              tx_state_d = UART_IDLE;
              tx_idx_d   = '0;
            end
          endcase
        end else begin
          tx_cnt_d = tx_cnt + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_len   <= DIVISOR_RESET;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_len   <= tx_len_d;
      tx_idx   <= tx_idx_d;
      tx_shift <= tx_shift_d;
    end
  end

  // Decoded straight from state so reset forces the line high without a clock.
  always_comb begin
    case (tx_state)
      UART_START: uart_tx = 1'b0;
      UART_DATA:  uart_tx = tx_shift[0];
      default:    uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver: after a bad stop bit the line must be seen high before rearming.
  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_len_d    = rx_len;
    rx_idx_d    = rx_idx;
    rx_shift_d  = rx_shift;
    rx_armed_d  = rx_armed;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      UART_IDLE: begin
        if (rx_sync) begin
          rx_armed_d = 1'b1;
        end else if (rx_armed) begin
          rx_state_d = UART_START;
          rx_cnt_d   = '0;
          rx_len_d   = divisor;
        end
      end
      UART_START: begin
        if (rx_cnt == (rx_len >> 1) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_len_d   = divisor;
          rx_idx_d   = '0;
          rx_state_d = rx_sync ? UART_IDLE : UART_DATA;
        end else begin
          rx_cnt_d = rx_cnt + 16'd1;
        end
      end
      UART_DATA: begin
        if (rx_cnt == rx_len - 16'd1) begin
          rx_cnt_d   = '0;
          rx_len_d   = divisor;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          if (rx_idx == UART_LAST_BIT) rx_state_d = UART_STOP;
          else                         rx_idx_d   = rx_idx + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + 16'd1;
        end
      end
      default: begin
        if (rx_cnt == rx_len - 16'd1) begin
          rx_cnt_d    = '0;
          rx_idx_d    = '0;
          rx_state_d  = UART_IDLE;
          rx_armed_d  = rx_sync;
          rx_stop_ok  = rx_sync;
          rx_stop_bad = !rx_sync;
        end else begin
          rx_cnt_d = rx_cnt + 16'd1;
        end
      end
    endcase
  end

  assign rx_overrun_set = rx_stop_ok && rx_full && !rx_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_len   <= DIVISOR_RESET;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b1;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_len   <= rx_len_d;
      rx_idx   <= rx_idx_d;
      rx_shift <= rx_shift_d;
      rx_armed <= rx_armed_d;
    end
  end

  a_no_simultaneous_rw: assert property (@(posedge clk) disable iff (reset)
    !(io_read_en && io_write_en));

endmodule
